// File: rtl/lsu_bus_master.sv
// MEM-stage load/store initiator: converts MemRead/MemWrite strobes into a single
// outstanding valid/ready bus transaction, stalling the pipeline until it completes.
module lsu_bus_master #(
  parameter int unsigned WORD    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [WORD-1:0] ALUResult_in,
  input  logic [WORD-1:0] MemWriteData,
  output logic            Stall,
  output logic            Done,
  output logic            Fault,
  output logic [WORD-1:0] MemReadData,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_write,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic            mem_rsp_valid,
  input  logic [WORD-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RESP = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            write_q, write_d;
  logic            done_q, done_d;
  logic            fault_q, fault_d;
  logic [WORD-1:0] addr_q, addr_d;
  logic [WORD-1:0] wdata_q, wdata_d;
  logic [WORD-1:0] rdata_q, rdata_d;
  logic            stall_c;
  logic            acc;
  logic            bad;
  logic            expired;

  assign acc     = MemRead | MemWrite;
  assign bad     = (MemRead & MemWrite) | (ALUResult_in[1:0] != 2'b00);
  // The current cycle is the last one allowed before the transaction times out.
  assign expired = (cnt_q >= LAST);

  // Next-state, datapath latching and stall decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    stall_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_c = acc;
        if (acc) begin
          if (bad) begin
            state_d = ERR;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
            addr_d  = ALUResult_in;
            wdata_d = MemWriteData;
            write_d = MemWrite;
          end
        end
      end
      REQ: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (mem_req_ready) state_d = RESP;
        else if (expired)  state_d = ERR;
      end
      RESP: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (mem_rsp_valid) begin
          state_d = DONE;
          if (!write_q) rdata_d = mem_rdata;
        end else if (expired) begin
          state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == REQ);
    done_d  = (state_d == DONE);
    fault_d = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      write_q <= write_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Stall is forced low while reset is asserted so the pipeline is released at once.
  assign Stall         = reset & stall_c;
  assign Done          = done_q;
  assign Fault         = fault_q;
  assign MemReadData   = rdata_q;
  assign mem_req_valid = valid_q;
  assign mem_req_write = write_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: one instance with the default timeout and one
// with TIMEOUT=4, driven by a bench-side responder and a reference memory.
module tb_lsu_bus_master;

  logic        clk;
  logic        reset;
  logic        MemRead, MemWrite, to_rd, to_wr;
  logic [31:0] ALUResult_in, MemWriteData;
  logic        mem_req_ready, mem_rsp_valid;
  logic [31:0] mem_rdata;

  logic        Stall_a, Done_a, Fault_a, valid_a, write_a;
  logic [31:0] rdata_a, addr_a, wdata_a;
  logic        Stall_b, Done_b, Fault_b, valid_b, write_b;
  logic [31:0] rdata_b, addr_b, wdata_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] ref_last;

  lsu_bus_master #(.WORD(32), .TIMEOUT(255)) u_dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUResult_in(ALUResult_in), .MemWriteData(MemWriteData),
    .Stall(Stall_a), .Done(Done_a), .Fault(Fault_a), .MemReadData(rdata_a),
    .mem_req_valid(valid_a), .mem_req_ready(mem_req_ready), .mem_req_write(write_a),
    .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata)
  );

  lsu_bus_master #(.WORD(32), .TIMEOUT(4)) u_to (
    .clk(clk), .reset(reset), .MemRead(to_rd), .MemWrite(to_wr),
    .ALUResult_in(ALUResult_in), .MemWriteData(MemWriteData),
    .Stall(Stall_b), .Done(Done_b), .Fault(Fault_b), .MemReadData(rdata_b),
    .mem_req_valid(valid_b), .mem_req_ready(mem_req_ready), .mem_req_write(write_b),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a, input bit from_slave);
    if (from_slave) return slave_mem.exists(a) ? slave_mem[a] : 32'h0;
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // One aligned access on u_dut with the given REQ and RESP wait states.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int req_wait, input int rsp_wait);
    logic [31:0] rsp_data;
    logic [31:0] exp_rd;
    exp_rd = rd ? mem_rd(addr, 1'b0) : ref_last;
    rsp_data = 32'h0;
    MemRead = rd; MemWrite = wr; ALUResult_in = addr; MemWriteData = wdata;
    #1;
    chk("idle_acc_stall", 32'(Stall_a), 32'd1);
    chk("idle_no_valid", 32'(valid_a), 32'd0);
    tick();
    for (int i = 0; i < req_wait; i++) begin
      chk("req_wait_valid", 32'(valid_a), 32'd1);
      chk("req_wait_addr", addr_a, addr);
      if (wr) chk("req_wait_wdata", wdata_a, wdata);
      chk("req_wait_done", 32'(Done_a), 32'd0);
      tick();
    end
    chk("req_valid", 32'(valid_a), 32'd1);
    chk("req_stall", 32'(Stall_a), 32'd1);
    chk("req_addr", addr_a, addr);
    chk("req_write", 32'(write_a), 32'(wr));
    if (wr) chk("req_wdata", wdata_a, wdata);
    mem_req_ready = 1'b1;
    if (write_a) slave_mem[addr_a] = wdata_a;
    else rsp_data = mem_rd(addr_a, 1'b1);
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < rsp_wait; i++) begin
      chk("resp_wait_stall", 32'(Stall_a), 32'd1);
      chk("resp_wait_valid", 32'(valid_a), 32'd0);
      chk("resp_wait_done", 32'(Done_a), 32'd0);
      tick();
    end
    chk("resp_stall", 32'(Stall_a), 32'd1);
    mem_rsp_valid = 1'b1;
    mem_rdata = rd ? rsp_data : 32'hBAD0_BAD0;
    tick();
    mem_rsp_valid = 1'b0;
    chk("done_pulse", 32'(Done_a), 32'd1);
    chk("done_stall", 32'(Stall_a), 32'd0);
    chk("done_fault", 32'(Fault_a), 32'd0);
    chk("done_rdata", rdata_a, exp_rd);
    MemRead = 1'b0; MemWrite = 1'b0;
    tick();
    chk("after_done", 32'(Done_a), 32'd0);
    chk("after_valid", 32'(valid_a), 32'd0);
    if (wr) ref_mem[addr] = wdata;
    if (rd) ref_last = exp_rd;
  endtask

  // Misaligned or conflicting strobe on u_dut: one stall cycle, then a Fault pulse.
  task automatic do_fault(input logic rd, input logic wr, input logic [31:0] addr);
    MemRead = rd; MemWrite = wr; ALUResult_in = addr; MemWriteData = 32'h0;
    #1;
    chk("flt_stall", 32'(Stall_a), 32'd1);
    chk("flt_no_valid", 32'(valid_a), 32'd0);
    tick();
    chk("flt_pulse", 32'(Fault_a), 32'd1);
    chk("flt_no_done", 32'(Done_a), 32'd0);
    chk("flt_stall_low", 32'(Stall_a), 32'd0);
    chk("flt_valid_low", 32'(valid_a), 32'd0);
    MemRead = 1'b0; MemWrite = 1'b0;
    tick();
    chk("flt_cleared", 32'(Fault_a), 32'd0);
    chk("flt_rdata_kept", rdata_a, ref_last);
  endtask

  initial begin
    reset = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; to_rd = 1'b0; to_wr = 1'b0;
    ALUResult_in = 32'h0; MemWriteData = 32'h0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
    ref_last = 32'h0;
    #3;
    chk("rst_stall", 32'(Stall_a), 32'd0);
    chk("rst_done", 32'(Done_a), 32'd0);
    chk("rst_fault", 32'(Fault_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_write", 32'(write_a), 32'd0);
    chk("rst_addr", addr_a, 32'h0);
    chk("rst_wdata", wdata_a, 32'h0);
    chk("rst_rdata", rdata_a, 32'h0);
    #9;
    reset = 1'b1;
    tick();

    // 1) zero-wait load
    slave_mem[32'h10] = 32'hDEAD_BEEF;
    ref_mem[32'h10]   = 32'hDEAD_BEEF;
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 0, 0);
    chk("t1_rdata", rdata_a, 32'hDEAD_BEEF);

    // 2) store with 3 ready waits and response two cycles after accept
    do_access(1'b0, 1'b1, 32'h24, 32'h1234_5678, 3, 1);
    chk("t2_rdata_unchanged", rdata_a, 32'hDEAD_BEEF);

    // 3) misaligned load, then both strobes set
    do_fault(1'b1, 1'b0, 32'h13);
    do_fault(1'b1, 1'b1, 32'h20);

    // 4a) TIMEOUT=4 instance, ready never asserted
    to_rd = 1'b1; ALUResult_in = 32'h40;
    #1;
    chk("t4_stall", 32'(Stall_b), 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t4_req_valid", 32'(valid_b), 32'd1);
      chk("t4_req_fault", 32'(Fault_b), 32'd0);
      tick();
    end
    chk("t4_fault", 32'(Fault_b), 32'd1);
    chk("t4_valid_dropped", 32'(valid_b), 32'd0);
    chk("t4_no_done", 32'(Done_b), 32'd0);
    to_rd = 1'b0;
    tick();
    chk("t4_fault_clear", 32'(Fault_b), 32'd0);
    chk("t4_valid_idle", 32'(valid_b), 32'd0);

    // 4b) response lands in the fourth REQ+RESP cycle
    to_rd = 1'b1; ALUResult_in = 32'h44;
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rsp_valid = 1'b0; to_rd = 1'b0;
    chk("t4b_done", 32'(Done_b), 32'd1);
    chk("t4b_no_fault", 32'(Fault_b), 32'd0);
    chk("t4b_rdata", rdata_b, 32'hCAFE_F00D);
    tick();
    chk("t4b_done_clear", 32'(Done_b), 32'd0);
    chk("t4b_dut_idle", 32'(Done_a), 32'd0);

    // 5) reset while in RESP, then a late response
    MemRead = 1'b1; ALUResult_in = 32'h30;
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("t5_valid", 32'(valid_a), 32'd0);
    chk("t5_stall", 32'(Stall_a), 32'd0);
    chk("t5_rdata", rdata_a, 32'h0);
    chk("t5_addr", addr_a, 32'h0);
    MemRead = 1'b0;
    reset = 1'b1;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h55AA_55AA;
    tick();
    tick();
    mem_rsp_valid = 1'b0;
    chk("t5_late_done", 32'(Done_a), 32'd0);
    chk("t5_late_rdata", rdata_a, 32'h0);
    chk("t5_late_stall", 32'(Stall_a), 32'd0);
    chk("t5_late_valid", 32'(valid_a), 32'd0);
    ref_last = 32'h0;

    // 6) back-to-back traffic with random wait states
    do_access(1'b0, 1'b1, 32'h100, 32'hA5A5_0001, $urandom_range(0, 3), $urandom_range(0, 3));
    do_access(1'b1, 1'b0, 32'h100, 32'h0,         $urandom_range(0, 3), $urandom_range(0, 3));
    do_access(1'b0, 1'b1, 32'h104, 32'h5A5A_0002, $urandom_range(0, 3), $urandom_range(0, 3));
    do_access(1'b1, 1'b0, 32'h104, 32'h0,         $urandom_range(0, 3), $urandom_range(0, 3));
    do_access(1'b0, 1'b1, 32'h100, 32'h0BAD_C0DE, $urandom_range(0, 3), $urandom_range(0, 3));
    do_access(1'b1, 1'b0, 32'h100, 32'h0,         $urandom_range(0, 3), $urandom_range(0, 3));
    do_access(1'b1, 1'b0, 32'h10,  32'h0,         $urandom_range(0, 3), $urandom_range(0, 3));
    chk("t6_final_rdata", rdata_a, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
